// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA blocks, valid/ready streaming.
// Latency: STAGES = ceil((WIDTH/4)/BLKS_PER_STAGE) cycles, the capture edge included; 1 beat/cycle.
// Backpressure: global stall; out_valid & ~out_ready freezes every stage and drops in_ready.
module adder_cla_pipe #(
    parameter int WIDTH          = 16,
    parameter int BLKS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    // Clamped so a bad parameter reaches the elaboration error below instead of a divide by zero.
    localparam int BPS    = (BLKS_PER_STAGE < 1) ? 1 : BLKS_PER_STAGE;
    localparam int NBLK   = (WIDTH < 4) ? 1 : WIDTH / 4;
    localparam int STAGES = (NBLK + BPS - 1) / BPS;

    if ((WIDTH % 4 != 0) || (WIDTH < 4) || (BLKS_PER_STAGE < 1)) begin : g_bad_param
        $error("adder_cla_pipe: WIDTH must be a multiple of 4 and >= 4, BLKS_PER_STAGE must be >= 1");
    end

    // One beat as it travels: conditioned operands, sum bits so far, carry into the next block.
    typedef struct packed {
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [WIDTH-1:0] sum;
        logic             cy;
        logic             cy_msb;
    } beat_t;

    // Returns {c4, c3, sum[3:0]}; c3 is kept so the MSB block can report the carry into the top bit.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, p ^ {c3, c2, c1, c0}};
    endfunction

    logic  adv;
    beat_t in_beat;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        in_beat.opa    = a;
        in_beat.opb    = b ^ {WIDTH{sub}};
        in_beat.sum    = '0;
        in_beat.cy     = c_in ^ sub;
        in_beat.cy_msb = 1'b0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        beat_t      src;
        beat_t      beat_d;
        beat_t      beat_q;
        logic       src_vld;
        logic       vld_q;
        logic [5:0] blk_r;
        logic       blk_c;

        if (k == 0) begin : g_head
            assign src     = in_beat;
            assign src_vld = in_valid;
        end else begin : g_link
            assign src     = g_stage[k-1].beat_q;
            assign src_vld = g_stage[k-1].vld_q;
        end

        // Blocks owned by this stage ripple their block carries; all other bits pass through.
        always_comb begin
            beat_d = src;
            blk_c  = src.cy;
            blk_r  = '0;
            for (int j = 0; j < BPS; j++) begin
                if (k * BPS + j < NBLK) begin
                    blk_r = cla4(src.opa[(k*BPS+j)*4 +: 4], src.opb[(k*BPS+j)*4 +: 4], blk_c);
                    beat_d.sum[(k*BPS+j)*4 +: 4] = blk_r[3:0];
                    blk_c = blk_r[5];
                    if (k * BPS + j == NBLK - 1) begin
                        beat_d.cy_msb = blk_r[4];
                    end
                end
            end
            beat_d.cy = blk_c;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                beat_q <= '0;
                vld_q  <= 1'b0;
            end else if (adv) begin
                beat_q <= beat_d;
                vld_q  <= src_vld;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign s         = g_stage[STAGES-1].beat_q.sum;
    assign c_out     = g_stage[STAGES-1].beat_q.cy;
    assign ovf       = g_stage[STAGES-1].beat_q.cy ^ g_stage[STAGES-1].beat_q.cy_msb;

    // Operands are fully consumed by the last stage; its copies feed nothing.
    logic unused_tail;
    assign unused_tail = ^{g_stage[STAGES-1].beat_q.opa, g_stage[STAGES-1].beat_q.opb};

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Bench for adder_cla_pipe: 16-bit/1-block pipe with scoreboard, plus an 8-bit/2-block instance.
module tb_adder_cla_pipe;
    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, s;
    logic        in_valid8, in_ready8, c8, sub8, out_valid8, out_ready8, c_out8, ovf8;
    logic [7:0]  a8, b8, s8;

    int          vectors = 0;
    int          miscompares = 0;
    int          edge_cnt = 0;
    logic [17:0] exp_q[$];
    int          edge_q[$];
    bit          lat_chk = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_s, last_s;
    logic        prev_c, prev_o, last_c, last_o;
    logic [17:0] e8;

    always #5 clk = ~clk;

    adder_cla_pipe #(.WIDTH(16), .BLKS_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
    );

    adder_cla_pipe #(.WIDTH(8), .BLKS_PER_STAGE(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8), .s(s8), .c_out(c_out8), .ovf(ovf8)
    );

    // Integer arithmetic on the stated rules; returns {ovf, c_out, s}.
    function automatic logic [17:0] ref_model(input int w, input logic [15:0] x, input logic [15:0] y,
                                              input logic cin, input logic sb);
        longint m, ua, ub, ci, r, sa, sy, sr;
        logic [15:0] so;
        logic co, oo;
        m  = longint'(1) << w;
        ua = longint'(x) & (m - 1);
        ub = longint'(y) & (m - 1);
        ci = cin ? 1 : 0;
        r  = sb ? (ua - ub - ci) : (ua + ub + ci);
        co = sb ? (r >= 0) : (r >= m);
        so = 16'(r & (m - 1));
        sa = (ua >= m / 2) ? ua - m : ua;
        sy = (ub >= m / 2) ? ub - m : ub;
        sr = sb ? (sa - sy - ci) : (sa + sy + ci);
        oo = (sr >= m / 2) || (sr < -(m / 2));
        return {oo, co, so};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        logic [17:0] e;
        int          n;
        bit          acc, fire;
        @(negedge clk);
        acc  = in_valid && in_ready;
        fire = out_valid && out_ready;
        if (prev_stall) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_s", 32'(s), 32'(prev_s));
            check("hold_c_out", 32'(c_out), 32'(prev_c));
            check("hold_ovf", 32'(ovf), 32'(prev_o));
        end
        if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
        if (fire) begin
            if (exp_q.size() == 0) begin
                check("out_with_empty_model", 32'(fire), 32'd0);
            end else begin
                e = exp_q.pop_front();
                n = edge_q.pop_front();
                check("s", 32'(s), 32'(e[15:0]));
                check("c_out", 32'(c_out), 32'(e[16]));
                check("ovf", 32'(ovf), 32'(e[17]));
                if (lat_chk) check("latency", 32'(edge_cnt + 1 - n), STAGES);
                last_s = s;
                last_c = c_out;
                last_o = ovf;
            end
        end
        if (acc) begin
            exp_q.push_back(ref_model(16, a, b, c_in, sub));
            edge_q.push_back(edge_cnt + 1);
        end
        prev_stall = out_valid && !out_ready;
        prev_s = s;
        prev_c = c_out;
        prev_o = ovf;
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_beat();
        a     = 16'($urandom);
        b     = 16'($urandom);
        c_in  = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic expect_one(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xs,
                              input logic [15:0] es, input logic ec, input logic eo);
        lat_chk  = 1'b1;
        out_ready = 1'b1;
        a = xa; b = xb; c_in = xc; sub = xs; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();
        check("dir_s", 32'(last_s), 32'(es));
        check("dir_c_out", 32'(last_c), 32'(ec));
        check("dir_ovf", 32'(last_o), 32'(eo));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0;
        last_s = '0; last_c = 1'b0; last_o = 1'b0; prev_s = '0; prev_c = 1'b0; prev_o = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Carry ripple through all blocks, then both subtract cases.
        expect_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        expect_one(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        expect_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back stream with constant latency.
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_beat();
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        drain();

        // Random bubbles and random consumer stalls.
        lat_chk = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Full pipe held for 3 cycles, then released.
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            in_valid = 1'b1;
            cyc();
        end
        check("full_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_beat();
            cyc();
        end
        in_valid = 1'b0;
        drain();

        // Reset with beats in flight.
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_c_out", 32'(c_out), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        edge_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        edge_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        expect_one(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        // 8-bit instance, two blocks per stage: single-cycle latency.
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
        check("w8_in_ready", 32'(in_ready8), 32'd1);
        cyc();
        check("w8_out_valid", 32'(out_valid8), 32'd1);
        check("w8_s", 32'(s8), 32'h81);
        check("w8_c_out", 32'(c_out8), 32'd0);
        check("w8_ovf", 32'(ovf8), 32'd1);
        for (int i = 0; i < 16; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sub8 = 1'($urandom);
            e8 = ref_model(8, {8'h00, a8}, {8'h00, b8}, c8, sub8);
            cyc();
            check("w8_rand_vld", 32'(out_valid8), 32'd1);
            check("w8_rand_s", 32'(s8), 32'(e8[7:0]));
            check("w8_rand_c_out", 32'(c_out8), 32'(e8[16]));
            check("w8_rand_ovf", 32'(ovf8), 32'(e8[17]));
        end
        in_valid8 = 1'b0;
        cyc();
        check("w8_bubble", 32'(out_valid8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
